mce_cell: RTL and testbench

- Compare-exchange element for the median-filter datapath: orders two unsigned samples A and B into MAX and MIN.
- The ordered pair is available combinationally, and also through a one-stage registered path with valid tracking for the pipelined sorting network.
- Instantiated repeatedly inside the median sorter. Each instance is independent.

---
 rtl/mce_cell_if.sv | 28 ++
 rtl/mce_cell.sv | 34 +++
 tb/tb_mce_cell.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mce_cell_if.sv
// Compare-exchange cell bus: operand pair in, ordered pair out.
// master drives A/B/IN_VALID; slave returns MAX/MIN/SWAP and registered copies.
interface mce_cell_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             IN_VALID;
  logic [WIDTH-1:0] MAX;
  logic [WIDTH-1:0] MIN;
  logic             SWAP;
  logic [WIDTH-1:0] MAX_Q;
  logic [WIDTH-1:0] MIN_Q;
  logic             SWAP_Q;
  logic             OUT_VALID;

  modport master (
    output A, B, IN_VALID,
    input  MAX, MIN, SWAP,
    input  MAX_Q, MIN_Q, SWAP_Q, OUT_VALID
  );

  modport slave (
    input  A, B, IN_VALID,
    output MAX, MIN, SWAP,
    output MAX_Q, MIN_Q, SWAP_Q, OUT_VALID
  );
endinterface

// File: rtl/mce_cell.sv
// Compare-exchange element: orders unsigned A/B into MAX/MIN.
// Ports: CLK, RST (async high), bus (slave): comb MAX/MIN/SWAP + 1-cycle regs.
module mce_cell #(
  parameter int WIDTH = 8
) (
  input logic  CLK,
  input logic  RST,
  mce_cell_if.slave bus
);

  logic swap;

  // Ties keep A on MAX, so SWAP is strictly A < B.
  assign swap     = bus.A < bus.B;
  assign bus.SWAP = swap;
  assign bus.MAX  = swap ? bus.B : bus.A;
  assign bus.MIN  = swap ? bus.A : bus.B;

  // Data regs load every cycle; OUT_VALID is the only qualifier.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.MAX_Q     <= '0;
      bus.MIN_Q     <= '0;
      bus.SWAP_Q    <= 1'b0;
      bus.OUT_VALID <= 1'b0;
    end else begin
      bus.MAX_Q     <= bus.MAX;
      bus.MIN_Q     <= bus.MIN;
      bus.SWAP_Q    <= swap;
      bus.OUT_VALID <= bus.IN_VALID;
    end
  end

endmodule

// File: tb/tb_mce_cell.sv
// Self-checking bench for mce_cell.
// Directed vectors plus a random sweep against a behavioural model.
module tb_mce_cell;

  localparam int W = 8;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  mce_cell_if #(.WIDTH(W)) bus ();

  mce_cell #(.WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Model: ordering rules written directly from the definition.
  function automatic logic [W-1:0] hi(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a >= b) return a;
    return b;
  endfunction

  function automatic logic [W-1:0] lo(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a >= b) return b;
    return a;
  endfunction

  // Model of the registered path: last pair seen at a clean edge.
  logic [W-1:0] m_max_q, m_min_q;
  logic         m_swap_q, m_valid_q;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_max_q   <= '0;
      m_min_q   <= '0;
      m_swap_q  <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      m_max_q   <= hi(bus.A, bus.B);
      m_min_q   <= lo(bus.A, bus.B);
      m_swap_q  <= (bus.A != bus.B) && (hi(bus.A, bus.B) == bus.B);
      m_valid_q <= bus.IN_VALID;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("cyc_max", 32'(bus.MAX), 32'(hi(bus.A, bus.B)));
      chk("cyc_min", 32'(bus.MIN), 32'(lo(bus.A, bus.B)));
      chk("cyc_max_q", 32'(bus.MAX_Q), 32'(m_max_q));
      chk("cyc_min_q", 32'(bus.MIN_Q), 32'(m_min_q));
      chk("cyc_swap_q", 32'(bus.SWAP_Q), 32'(m_swap_q));
      chk("cyc_valid", 32'(bus.OUT_VALID), 32'(m_valid_q));
    end
  end

  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic v);
    @(posedge CLK);
    #2;
    bus.A        = a;
    bus.B        = b;
    bus.IN_VALID = v;
  endtask

  task automatic comb(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] emax, input logic [W-1:0] emin,
                      input logic eswap);
    apply(a, b, 1'b0);
    #1;
    chk("comb_max", 32'(bus.MAX), 32'(emax));
    chk("comb_min", 32'(bus.MIN), 32'(emin));
    chk("comb_swap", 32'(bus.SWAP), 32'(eswap));
  endtask

  logic [W-1:0] ra, rb;
  logic [W-1:0] pa [3];
  logic [W-1:0] pb [3];
  logic [W-1:0] ex_hi [3];
  logic [W-1:0] ex_lo [3];

  initial begin
    RST          = 1'b1;
    bus.A        = '0;
    bus.B        = '0;
    bus.IN_VALID = 1'b0;
    #3;
    chk("rst_max_q", 32'(bus.MAX_Q), 32'd0);
    chk("rst_min_q", 32'(bus.MIN_Q), 32'd0);
    chk("rst_swap_q", 32'(bus.SWAP_Q), 32'd0);
    chk("rst_valid", 32'(bus.OUT_VALID), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST    = 1'b0;
    chk_en = 1'b1;

    comb(8'd200, 8'd17, 8'd200, 8'd17, 1'b0);
    comb(8'd17, 8'd200, 8'd200, 8'd17, 1'b1);
    comb(8'h55, 8'h55, 8'h55, 8'h55, 1'b0);
    comb(8'd0, 8'd255, 8'd255, 8'd0, 1'b1);
    comb(8'd255, 8'd0, 8'd255, 8'd0, 1'b0);

    // Registered latency and valid drop.
    apply(8'd10, 8'd3, 1'b1);
    @(posedge CLK);
    #1;
    chk("lat_max_q", 32'(bus.MAX_Q), 32'd10);
    chk("lat_min_q", 32'(bus.MIN_Q), 32'd3);
    chk("lat_swap_q", 32'(bus.SWAP_Q), 32'd0);
    chk("lat_valid", 32'(bus.OUT_VALID), 32'd1);
    #1;
    bus.IN_VALID = 1'b0;
    @(posedge CLK);
    #1;
    chk("lat_valid_drop", 32'(bus.OUT_VALID), 32'd0);

    // Back-to-back pairs.
    pa = '{8'd1, 8'd9, 8'd7};
    pb = '{8'd2, 8'd4, 8'd7};
    ex_hi = '{8'd2, 8'd9, 8'd7};
    ex_lo = '{8'd1, 8'd4, 8'd7};
    apply(pa[0], pb[0], 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      chk("b2b_max_q", 32'(bus.MAX_Q), 32'(ex_hi[i]));
      chk("b2b_min_q", 32'(bus.MIN_Q), 32'(ex_lo[i]));
      chk("b2b_valid", 32'(bus.OUT_VALID), 32'd1);
      #1;
      if (i < 2) begin
        bus.A = pa[i+1];
        bus.B = pb[i+1];
      end else begin
        bus.IN_VALID = 1'b0;
      end
    end

    // Async reset between edges.
    apply(8'd40, 8'd90, 1'b1);
    @(posedge CLK);
    #1;
    chk("pre_rst_valid", 32'(bus.OUT_VALID), 32'd1);
    chk("pre_rst_swap_q", 32'(bus.SWAP_Q), 32'd1);
    #1;
    RST = 1'b1;
    #1;
    chk("arst_max_q", 32'(bus.MAX_Q), 32'd0);
    chk("arst_min_q", 32'(bus.MIN_Q), 32'd0);
    chk("arst_swap_q", 32'(bus.SWAP_Q), 32'd0);
    chk("arst_valid", 32'(bus.OUT_VALID), 32'd0);
    bus.A = 8'd3;
    bus.B = 8'd250;
    #1;
    chk("arst_comb_max", 32'(bus.MAX), 32'd250);
    chk("arst_comb_min", 32'(bus.MIN), 32'd3);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("post_rst_max_q", 32'(bus.MAX_Q), 32'd250);
    chk("post_rst_min_q", 32'(bus.MIN_Q), 32'd3);
    chk("post_rst_valid", 32'(bus.OUT_VALID), 32'd1);

    // Random sweep with toggling valid.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      apply(ra, rb, 1'(i % 2));
      #1;
      if (bus.MAX !== hi(ra, rb) || bus.MIN !== lo(ra, rb)) begin
        chk("rnd_max", 32'(bus.MAX), 32'(hi(ra, rb)));
        chk("rnd_min", 32'(bus.MIN), 32'(lo(ra, rb)));
        break;
      end
      checks++;
    end

    @(posedge CLK);
    @(negedge CLK);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
